md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 14 +
 rtl/md_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/md_pkg.sv
// md_pkg: op encodings, FSM states and default latencies shared by the multiply/divide unit.
package md_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;
    typedef enum logic {IDLE, RUN} state_e;
    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    state_e             state;
    logic        [5:0]  cnt;
    logic        [31:0] hi_t, lo_t;
    logic               is_md, is_mul, ovf;
    logic        [31:0] b_safe, quo_s, rem_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u, res;

    assign is_md     = op < OP_MTHI;
    assign is_mul    = op == OP_MULT || op == OP_MULTU;
    assign stall_req = busy | (start & is_md);

    // The divisor is forced to 1 on divide-by-zero and INT_MIN/-1 so the native operators never trap.
    always_comb begin
        ovf    = A == 32'h8000_0000 && B == 32'hFFFF_FFFF;
        b_safe = (B == 32'd0 || ovf) ? 32'd1 : B;
        prod_s = 64'($signed(A)) * 64'($signed(B));
        prod_u = {32'd0, A} * {32'd0, B};
        quo_s  = $signed(A) / $signed(b_safe);
        rem_s  = $signed(A) % $signed(b_safe);
        res    = op == OP_MULT  ? prod_s :
                 op == OP_MULTU ? prod_u :
                 B == 32'd0     ? {HI, LO} :
                 op == OP_DIV   ? (ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s}) :
                                  {A % b_safe, A / b_safe};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi_t  <= '0;
            lo_t  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (is_md) begin
                        {hi_t, lo_t} <= res;
                        cnt          <= is_mul ? 6'(MUL_CYCLES) : 6'(DIV_CYCLES);
                        busy         <= 1'b1;
                        state        <= RUN;
                    end else if (op == OP_MTHI) begin
                        HI <= A;
                    end else if (op == OP_MTLO) begin
                        LO <= A;
                    end
                end
                RUN: begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        HI    <= hi_t;
                        LO    <= lo_t;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
